mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-port synchronous memory between the fetch stage and the memory stage of the 5-stage core. Data-side requests have fixed priority; an aging counter prevents fetch starvation. The block completes each access and returns a per-requester valid pulse. It also drives the pipeline-wide stall, which ORs with the load-use stall.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width; byte-enable width is DATA_W/8
MEM_LAT, 1, cycles from mem_cs edge to mem_rdata valid; legal range >=1
STARVE_MAX, 4, consecutive data grants allowed while fetch waits; legal range >=1

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
if_req  in  1  fetch request, level; held until if_valid or if_kill
if_addr  in  ADDR_W  fetch address
if_kill  in  1  cancel pending or in-flight fetch (taken jump/branch)
if_rdata  out  DATA_W  fetched word, meaningful when if_valid
if_valid  out  1  one-cycle completion pulse for fetch
dm_req  in  1  data request, level; held until dm_valid
dm_addr  in  ADDR_W  data address
dm_w_en  in  DATA_W/8  byte write enables; all-zero means read
dm_wdata  in  DATA_W  store data
dm_rdata  out  DATA_W  load data, meaningful when dm_valid
dm_valid  out  1  one-cycle completion pulse for data access (read or write)
mem_cs  out  1  memory access strobe, one cycle per access
mem_addr  out  ADDR_W  memory address
mem_w_en  out  DATA_W/8  memory byte write enables
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_cs
stall  out  1  (if_req & ~if_valid & ~if_kill) | (dm_req & ~dm_valid)

Behaviour:
- FSM states: IDLE, WAIT. Registered state: owner (IF/DM), lat_cnt, starve_cnt, killed flag.
- IDLE: no request -> mem_cs=0, stay in IDLE. Any request -> arbitrate combinationally in the same cycle and assert mem_cs for one cycle with the winner's addr/w_en/wdata. Latch owner, set lat_cnt=MEM_LAT, go to WAIT.
- Arbitration: dm_req wins, unless if_req is asserted and starve_cnt==STARVE_MAX, in which case fetch wins.
- starve_cnt increments on a DM grant while if_req=1, saturating at STARVE_MAX. It clears on any IF grant or when if_req=0 in IDLE.
- A fetch request with if_kill=1 in IDLE is not eligible.
- mem_w_en is driven only for DM grants and is 0 otherwise. mem_addr, mem_w_en and mem_wdata are 0 when mem_cs=0.
- WAIT: lat_cnt decrements each cycle. When lat_cnt==1, the owner's valid is asserted combinationally and its rdata is mem_rdata. Next state is IDLE.
- Throughput is one access per MEM_LAT+1 cycles. No new mem_cs is issued in a WAIT cycle.
- The non-owner's rdata output is 0. Both valids are 0 except in completion cycles.
- Writes take the same latency and receive dm_valid as the acknowledgement. dm_rdata during a write ack is don't-care, driven as mem_rdata.
- if_kill while owner=IF in WAIT: set killed. The access still completes on the memory, but if_valid is suppressed at completion. killed clears on return to IDLE.
- if_kill in the completion cycle itself also suppresses if_valid.
- Requester address changes while that requester is in WAIT are ignored; the latched access completes.
- Reset, including reset mid-access: state=IDLE, starve_cnt=0, killed=0, all outputs 0. The in-flight access is abandoned and no valid is produced.

Decomposition:
- Shared package holds the FSM state encoding (IDLE, WAIT) and the owner encoding (OWN_IF, OWN_DM). It also holds a localparam for the lat_cnt width, $clog2(MEM_LAT+1).
- One sub-module, arb_starve_counter: saturating counter with inc/clr/sat output, parameterized by STARVE_MAX.

Test Plan:
- MEM_LAT=1; read request if_req=1, if_addr=0x100, memory returns 0xDEADBEEF -> mem_cs pulse at cycle 0, if_valid=1 with if_rdata=0xDEADBEEF at cycle 1, stall=1 in cycle 0 only.
- Simultaneous if_req (0x200) and dm_req read (0x8000) -> DM granted first, with dm_valid at cycle 1. IF is granted at cycle 2, with if_valid at cycle 3.
- STARVE_MAX=4; dm_req and if_req held continuously -> grant order DM,DM,DM,DM,IF,DM,... and starve_cnt returns to 0 after the IF grant.
- Store dm_w_en=4'b0011, dm_wdata=0x0000ABCD, addr 0x40, MEM_LAT=3 -> mem_cs with mem_w_en=0011 in cycle 0, dm_valid in cycle 3, stall=1 for cycles 0-2.
- Fetch in flight with MEM_LAT=2, if_kill pulsed in cycle 1 -> no if_valid, FSM back in IDLE at cycle 3, next dm_req granted in cycle 3.
- rst asserted in WAIT cycle of a DM read -> all outputs 0 immediately, no dm_valid. After release, a held dm_req restarts the access from IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// State and owner encodings plus the latency counter sizing.
package mem_port_arbiter_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } arb_state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } arb_owner_e;

   localparam int unsigned MEM_LAT_DEF = 1;
   localparam int unsigned LAT_W_DEF   = $clog2(MEM_LAT_DEF + 1);

   // lat_cnt must hold MEM_LAT itself, hence the +1.
   function automatic int unsigned lat_cnt_w(input int unsigned lat);
      return $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bus of the shared memory port.
// slave is the arbiter's view, master the core/memory view.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) ();

   localparam int unsigned BE_W = DATA_W / 8;

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_kill;
   logic [DATA_W-1:0] if_rdata;
   logic              if_valid;

   logic              dm_req;
   logic [ADDR_W-1:0] dm_addr;
   logic [BE_W-1:0]   dm_w_en;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_valid;

   logic              mem_cs;
   logic [ADDR_W-1:0] mem_addr;
   logic [BE_W-1:0]   mem_w_en;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              stall;

   modport slave (
      input  if_req,
      input  if_addr,
      input  if_kill,
      output if_rdata,
      output if_valid,
      input  dm_req,
      input  dm_addr,
      input  dm_w_en,
      input  dm_wdata,
      output dm_rdata,
      output dm_valid,
      output mem_cs,
      output mem_addr,
      output mem_w_en,
      output mem_wdata,
      input  mem_rdata,
      output stall
   );

   modport master (
      output if_req,
      output if_addr,
      output if_kill,
      input  if_rdata,
      input  if_valid,
      output dm_req,
      output dm_addr,
      output dm_w_en,
      output dm_wdata,
      input  dm_rdata,
      input  dm_valid,
      input  mem_cs,
      input  mem_addr,
      input  mem_w_en,
      input  mem_wdata,
      output mem_rdata,
      input  stall
   );

endinterface

// File: rtl/mem_port_arbiter_starve.sv
// Saturating count of data grants taken while fetch is waiting.
// sat tells the arbiter to hand the next slot to fetch.
module arb_starve_counter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign sat = (cnt_q == CNT_W'(STARVE_MAX));

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && !sat) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for the single-port synchronous memory.
// Data has priority; fetch wins once STARVE_MAX data grants pass it.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);

   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned LAT_W = lat_cnt_w(MEM_LAT);

   arb_state_e       state_q;
   arb_state_e       state_d;
   arb_owner_e       owner_q;
   arb_owner_e       owner_d;
   logic [LAT_W-1:0] lat_q;
   logic [LAT_W-1:0] lat_d;
   logic             killed_q;
   logic             killed_d;

   logic if_elig;
   logic grant_if;
   logic grant_dm;
   logic st_inc;
   logic st_clr;
   logic st_sat;

   logic              cs;
   logic [ADDR_W-1:0] addr;
   logic [BE_W-1:0]   wen;
   logic [DATA_W-1:0] wdata;
   logic              if_v;
   logic              dm_v;
   logic [DATA_W-1:0] if_rd;
   logic [DATA_W-1:0] dm_rd;

   arb_starve_counter #(
      .STARVE_MAX(STARVE_MAX)
   ) u_starve (
      .clk(clk),
      .rst(rst),
      .inc(st_inc),
      .clr(st_clr),
      .sat(st_sat)
   );

   assign if_elig = bus.if_req & ~bus.if_kill;

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      lat_d    = lat_q;
      killed_d = killed_q;
      grant_if = 1'b0;
      grant_dm = 1'b0;
      st_inc   = 1'b0;
      st_clr   = 1'b0;
      cs       = 1'b0;
      addr     = '0;
      wen      = '0;
      wdata    = '0;
      if_v     = 1'b0;
      dm_v     = 1'b0;
      if_rd    = '0;
      dm_rd    = '0;
      case (state_q)
         S_IDLE: begin
            grant_dm = bus.dm_req & ~(if_elig & st_sat);
            grant_if = if_elig & ~grant_dm;
            st_inc   = grant_dm & bus.if_req;
            st_clr   = grant_if | ~bus.if_req;
            unique case (1'b1)
               grant_dm: begin
                  cs      = 1'b1;
                  addr    = bus.dm_addr;
                  wen     = bus.dm_w_en;
                  wdata   = bus.dm_wdata;
                  owner_d = OWN_DM;
               end
               grant_if: begin
                  cs      = 1'b1;
                  addr    = bus.if_addr;
                  owner_d = OWN_IF;
               end
               default: ;
            endcase
            if (cs) begin
               state_d  = S_WAIT;
               lat_d    = LAT_W'(MEM_LAT);
               killed_d = 1'b0;
            end
         end
         S_WAIT: begin
            lat_d = lat_q - LAT_W'(1);
            if (owner_q == OWN_IF && bus.if_kill) begin
               killed_d = 1'b1;
            end
            // Completion; a kill landing this cycle still drops if_valid.
            if (lat_q == LAT_W'(1)) begin
               state_d  = S_IDLE;
               killed_d = 1'b0;
               if (owner_q == OWN_DM) begin
                  dm_v  = 1'b1;
                  dm_rd = bus.mem_rdata;
               end else if (!killed_q && !bus.if_kill) begin
                  if_v  = 1'b1;
                  if_rd = bus.mem_rdata;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         owner_q  <= OWN_IF;
         lat_q    <= '0;
         killed_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         lat_q    <= lat_d;
         killed_q <= killed_d;
      end
   end

   // Outputs are forced low for the whole time reset is held.
   assign bus.mem_cs    = ~rst & cs;
   assign bus.mem_addr  = rst ? '0 : addr;
   assign bus.mem_w_en  = rst ? '0 : wen;
   assign bus.mem_wdata = rst ? '0 : wdata;
   assign bus.if_valid  = ~rst & if_v;
   assign bus.dm_valid  = ~rst & dm_v;
   assign bus.if_rdata  = rst ? '0 : if_rd;
   assign bus.dm_rdata  = rst ? '0 : dm_rd;

   assign bus.stall = ~rst & ((bus.if_req & ~if_v & ~bus.if_kill) |
                              (bus.dm_req & ~dm_v));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int BW  = DW / 8;
   localparam int LAT = 2;
   localparam int SM  = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   passes = 0;

   logic [31:0] mem_arr [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] pipe [LAT];

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_port_arbiter #(
      .ADDR_W(AW),
      .DATA_W(DW),
      .MEM_LAT(LAT),
      .STARVE_MAX(SM)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[15:0]};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o,
                                         input logic [31:0] w,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = w[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem_arr.exists(a) ? mem_arr[a] : dflt(a);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   // Memory: read data appears LAT cycles after the strobe.
   always @(posedge clk) begin
      pipe[0] <= bus.mem_cs ? mem_rd(bus.mem_addr) : 32'h0;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      if (bus.mem_cs)
         mem_arr[bus.mem_addr] = merge(mem_rd(bus.mem_addr),
                                       bus.mem_wdata, bus.mem_w_en);
   end
   assign bus.mem_rdata = pipe[LAT-1];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      bus.if_req   = 1'b0;
      bus.if_addr  = '0;
      bus.if_kill  = 1'b0;
      bus.dm_req   = 1'b0;
      bus.dm_addr  = '0;
      bus.dm_w_en  = '0;
      bus.dm_wdata = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      bus.if_req = 1'b1; bus.if_addr = 32'h20;
      bus.dm_req = 1'b1; bus.dm_addr = 32'h10;
      samp();
      checks++; if (bus.mem_cs !== 1'b0) $display("FAIL rst_cs got %b want 0", bus.mem_cs); else passes++;
      checks++; if (bus.mem_addr !== 32'h0) $display("FAIL rst_addr got %h want 0", bus.mem_addr); else passes++;
      checks++; if (bus.stall !== 1'b0) $display("FAIL rst_stall got %b want 0", bus.stall); else passes++;
      checks++; if ({bus.if_valid, bus.dm_valid} !== 2'b00) $display("FAIL rst_valid got %b want 00", {bus.if_valid, bus.dm_valid}); else passes++;
      step();
      clear_inputs();
      rst = 1'b0;
      repeat (2) step();
   endtask

   task automatic test_fetch();
      step();
      bus.if_req = 1'b1; bus.if_addr = 32'h100;
      for (int c = 0; c <= LAT; c++) begin
         if (c > 0) step();
         samp();
         checks++; if (bus.mem_cs !== (c == 0)) $display("FAIL fetch_cs c%0d got %b want %b", c, bus.mem_cs, c == 0); else passes++;
         checks++; if (bus.if_valid !== (c == LAT)) $display("FAIL fetch_valid c%0d got %b want %b", c, bus.if_valid, c == LAT); else passes++;
         checks++; if (bus.stall !== (c < LAT)) $display("FAIL fetch_stall c%0d got %b want %b", c, bus.stall, c < LAT); else passes++;
         if (c == 0) begin
            checks++; if (bus.mem_addr !== 32'h100) $display("FAIL fetch_addr got %h want 100", bus.mem_addr); else passes++;
         end
         if (c == LAT) begin
            checks++; if (bus.if_rdata !== 32'hDEADBEEF) $display("FAIL fetch_rdata got %h want deadbeef", bus.if_rdata); else passes++;
         end
      end
      step();
      clear_inputs();
      repeat (2) step();
   endtask

   task automatic test_priority();
      step();
      bus.if_req = 1'b1; bus.if_addr = 32'h200;
      bus.dm_req = 1'b1; bus.dm_addr = 32'h8000;
      for (int c = 0; c <= 2*LAT+1; c++) begin
         if (c > 0) step();
         if (c == LAT+1) bus.dm_req = 1'b0;
         samp();
         checks++; if (bus.mem_cs !== (c == 0 || c == LAT+1)) $display("FAIL prio_cs c%0d got %b", c, bus.mem_cs); else passes++;
         checks++; if (bus.dm_valid !== (c == LAT)) $display("FAIL prio_dm_valid c%0d got %b want %b", c, bus.dm_valid, c == LAT); else passes++;
         checks++; if (bus.if_valid !== (c == 2*LAT+1)) $display("FAIL prio_if_valid c%0d got %b want %b", c, bus.if_valid, c == 2*LAT+1); else passes++;
         if (c == 0) begin
            checks++; if (bus.mem_addr !== 32'h8000) $display("FAIL prio_first got %h want 8000", bus.mem_addr); else passes++;
         end
         if (c == LAT+1) begin
            checks++; if (bus.mem_addr !== 32'h200) $display("FAIL prio_second got %h want 200", bus.mem_addr); else passes++;
         end
         if (c == LAT) begin
            checks++; if (bus.dm_rdata !== ref_rd(32'h8000)) $display("FAIL prio_dm_rdata got %h want %h", bus.dm_rdata, ref_rd(32'h8000)); else passes++;
         end
      end
      step();
      clear_inputs();
      repeat (2) step();
   endtask

   task automatic test_starve();
      int g = 0;
      int cyc = 0;
      int sc = 0;
      bit e_if;
      bit is_if;
      step();
      bus.if_req = 1'b1; bus.if_addr = 32'h300;
      bus.dm_req = 1'b1; bus.dm_addr = 32'h4000;
      while (g < 10 && cyc < 200) begin
         samp();
         if (bus.mem_cs) begin
            e_if = (sc == SM);
            if (e_if) sc = 0; else sc++;
            is_if = (bus.mem_addr == 32'h300);
            checks++; if (is_if !== e_if) $display("FAIL starve_grant%0d got if=%b want if=%b", g, is_if, e_if); else passes++;
            g++;
         end
         cyc++;
         step();
      end
      checks++; if (g < 10) $display("FAIL starve_timeout got %0d grants want 10", g); else passes++;
      clear_inputs();
      repeat (LAT + 2) step();
   endtask

   task automatic test_store();
      logic [31:0] exp;
      step();
      bus.dm_req = 1'b1; bus.dm_addr = 32'h40;
      bus.dm_w_en = 4'b0011; bus.dm_wdata = 32'h0000ABCD;
      for (int c = 0; c <= LAT; c++) begin
         if (c > 0) step();
         samp();
         checks++; if (bus.dm_valid !== (c == LAT)) $display("FAIL store_valid c%0d got %b want %b", c, bus.dm_valid, c == LAT); else passes++;
         checks++; if (bus.stall !== (c < LAT)) $display("FAIL store_stall c%0d got %b want %b", c, bus.stall, c < LAT); else passes++;
         if (c == 0) begin
            checks++; if (bus.mem_cs !== 1'b1 || bus.mem_w_en !== 4'b0011) $display("FAIL store_wen got cs=%b wen=%b want 1/0011", bus.mem_cs, bus.mem_w_en); else passes++;
            checks++; if (bus.mem_wdata !== 32'h0000ABCD || bus.mem_addr !== 32'h40) $display("FAIL store_bus got %h@%h want abcd@40", bus.mem_wdata, bus.mem_addr); else passes++;
         end
      end
      ref_mem[32'h40] = merge(ref_rd(32'h40), 32'h0000ABCD, 4'b0011);
      exp = ref_mem[32'h40];
      step();
      bus.dm_w_en = 4'b0000; bus.dm_wdata = '0;
      for (int c = 0; c <= LAT; c++) begin
         if (c > 0) step();
         samp();
         if (c == 0) begin
            checks++; if (bus.mem_w_en !== 4'b0000) $display("FAIL load_wen got %b want 0000", bus.mem_w_en); else passes++;
         end
         if (c == LAT) begin
            checks++; if (bus.dm_valid !== 1'b1 || bus.dm_rdata !== exp) $display("FAIL load_back got v=%b %h want 1 %h", bus.dm_valid, bus.dm_rdata, exp); else passes++;
         end
      end
      step();
      clear_inputs();
      repeat (2) step();
   endtask

   task automatic test_kill();
      step();
      bus.if_req = 1'b1; bus.if_addr = 32'h500;
      samp();
      checks++; if (bus.mem_cs !== 1'b1) $display("FAIL kill_issue got %b want 1", bus.mem_cs); else passes++;
      step();
      bus.if_req = 1'b0; bus.if_kill = 1'b1;
      samp();
      checks++; if (bus.if_valid !== 1'b0) $display("FAIL kill_c1_valid got %b want 0", bus.if_valid); else passes++;
      for (int c = 2; c <= LAT + 1; c++) begin
         step();
         bus.if_kill = 1'b0;
         bus.dm_req = 1'b1; bus.dm_addr = 32'h600;
         samp();
         checks++; if (bus.if_valid !== 1'b0) $display("FAIL kill_valid c%0d got %b want 0", c, bus.if_valid); else passes++;
         checks++; if (bus.mem_cs !== (c == LAT + 1)) $display("FAIL kill_dm_cs c%0d got %b want %b", c, bus.mem_cs, c == LAT + 1); else passes++;
      end
      checks++; if (bus.mem_addr !== 32'h600) $display("FAIL kill_dm_addr got %h want 600", bus.mem_addr); else passes++;
      repeat (LAT) step();
      samp();
      checks++; if (bus.dm_valid !== 1'b1) $display("FAIL kill_dm_done got %b want 1", bus.dm_valid); else passes++;
      step();
      clear_inputs();
      repeat (2) step();
   endtask

   task automatic test_reset_mid();
      step();
      bus.dm_req = 1'b1; bus.dm_addr = 32'h700;
      samp();
      checks++; if (bus.mem_cs !== 1'b1) $display("FAIL rmid_issue got %b want 1", bus.mem_cs); else passes++;
      step();
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.mem_cs !== 1'b0 || bus.stall !== 1'b0) $display("FAIL rmid_now got cs=%b stall=%b want 0/0", bus.mem_cs, bus.stall); else passes++;
      checks++; if (bus.dm_valid !== 1'b0 || bus.dm_rdata !== 32'h0) $display("FAIL rmid_data got v=%b %h want 0", bus.dm_valid, bus.dm_rdata); else passes++;
      step();
      samp();
      checks++; if (bus.dm_valid !== 1'b0) $display("FAIL rmid_no_valid got %b want 0", bus.dm_valid); else passes++;
      step();
      rst = 1'b0;
      samp();
      checks++; if (bus.mem_cs !== 1'b1 || bus.mem_addr !== 32'h700) $display("FAIL rmid_restart got cs=%b %h want 1 700", bus.mem_cs, bus.mem_addr); else passes++;
      for (int c = 1; c <= LAT; c++) begin
         step();
         samp();
         checks++; if (bus.dm_valid !== (c == LAT)) $display("FAIL rmid_valid c%0d got %b want %b", c, bus.dm_valid, c == LAT); else passes++;
      end
      step();
      clear_inputs();
      repeat (2) step();
   endtask

   // Transaction model: one access at a time, each occupying LAT+1 cycles.
   task automatic test_random();
      bit ifp = 0, dmp = 0, kill, mk = 0, capw = 0, elig;
      int busy = 0, starve = 0, who = 0;
      logic [31:0] cap = '0;
      bit e_cs, e_iv, e_dv, e_st, e_mk;
      logic [31:0] e_addr;
      logic [3:0]  e_wen;
      step();
      rst = 1'b1;
      clear_inputs();
      step();
      rst = 1'b0;
      repeat (600) begin
         step();
         if (!ifp && $urandom_range(0, 2) == 0) begin
            ifp = 1;
            bus.if_addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
         end else if (ifp && busy > 0 && who == 0 && $urandom_range(0, 3) == 0) begin
            bus.if_addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
         end
         if (!dmp && $urandom_range(0, 1) == 0) begin
            dmp = 1;
            bus.dm_addr  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            bus.dm_w_en  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            bus.dm_wdata = $urandom;
         end else if (dmp && busy > 0 && who == 1 && $urandom_range(0, 3) == 0) begin
            bus.dm_addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
         end
         kill = ifp && ($urandom_range(0, 9) == 0);
         bus.if_req  = ifp;
         bus.if_kill = kill;
         bus.dm_req  = dmp;
         e_cs = 0; e_iv = 0; e_dv = 0; e_addr = '0; e_wen = '0; e_mk = mk;
         if (busy == 0) begin
            elig = ifp && !kill;
            if (dmp && !(elig && starve == SM)) begin
               e_cs = 1; e_addr = bus.dm_addr; e_wen = bus.dm_w_en;
               who = 1; capw = (bus.dm_w_en != 0);
               cap = ref_rd(bus.dm_addr);
               if (capw) ref_mem[bus.dm_addr] = merge(cap, bus.dm_wdata, bus.dm_w_en);
               starve = ifp ? ((starve < SM) ? starve + 1 : SM) : 0;
            end else if (elig) begin
               e_cs = 1; e_addr = bus.if_addr;
               who = 0; capw = 0;
               cap = ref_rd(bus.if_addr);
               starve = 0;
            end else if (!ifp) begin
               starve = 0;
            end
            if (e_cs) begin
               busy = LAT; e_mk = 0;
            end
         end else begin
            if (who == 0 && kill) e_mk = 1;
            if (busy == 1) begin
               if (who == 1) e_dv = 1;
               else if (!mk && !kill) e_iv = 1;
               e_mk = 0;
            end
            busy--;
         end
         mk = e_mk;
         e_st = (ifp && !e_iv && !kill) || (dmp && !e_dv);
         samp();
         checks++; if (bus.mem_cs !== e_cs) $display("FAIL rnd_cs got %b want %b", bus.mem_cs, e_cs); else passes++;
         if (e_cs) begin
            checks++; if (bus.mem_addr !== e_addr || bus.mem_w_en !== e_wen) $display("FAIL rnd_bus got %h/%b want %h/%b", bus.mem_addr, bus.mem_w_en, e_addr, e_wen); else passes++;
         end
         checks++; if (bus.if_valid !== e_iv) $display("FAIL rnd_if_valid got %b want %b", bus.if_valid, e_iv); else passes++;
         checks++; if (bus.dm_valid !== e_dv) $display("FAIL rnd_dm_valid got %b want %b", bus.dm_valid, e_dv); else passes++;
         checks++; if (bus.stall !== e_st) $display("FAIL rnd_stall got %b want %b", bus.stall, e_st); else passes++;
         if (e_iv) begin
            checks++; if (bus.if_rdata !== cap) $display("FAIL rnd_if_rdata got %h want %h", bus.if_rdata, cap); else passes++;
         end
         if (e_dv && !capw) begin
            checks++; if (bus.dm_rdata !== cap) $display("FAIL rnd_dm_rdata got %h want %h", bus.dm_rdata, cap); else passes++;
         end
         if (e_iv || kill) ifp = 0;
         if (e_dv) dmp = 0;
      end
      step();
      clear_inputs();
      repeat (LAT + 2) step();
   endtask

   initial begin
      mem_arr[32'h100] = 32'hDEADBEEF;
      ref_mem[32'h100] = 32'hDEADBEEF;
      test_reset();
      test_fetch();
      test_priority();
      test_starve();
      test_store();
      test_kill();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
